mem_access: RTL and testbench

// - MEM pipeline stage. Sits directly downstream of the execute stage and consumes its registered outputs
//   (pc_mem, alu_mem, rs2_mem, instr_mem).
// - Performs RV32I loads/stores over a req/ack data-memory port and stalls the upstream pipe while a

---
 rtl/mem_access.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_access.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Purpose : MEM pipeline stage; RV32I loads/stores over a req/ack data port, produces WB regs.
// Latency : non-mem ops 1 cycle; mem ops >= 2 cycles (stall cycle + ack cycle), ack-driven.
// Backpr. : stall holds IF/ID/EXE and this stage's inputs while a transfer is outstanding.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   valid_mem/pc_mem/alu_mem/       MEM-stage instruction from execute (alu_mem = address)
//   rs2_mem/instr_mem
//   stall                           hold upstream registers
//   dmem_req/we/addr/wdata/be       registered data-memory request (addr word aligned)
//   dmem_ack/dmem_rdata             transfer complete / load word (sampled on ack only)
//   valid_wb/pc_wb/instr_wb/        write-back stage registers
//   wb_data_wb, forward_mem         load result or ALU result; forward_mem mirrors wb_data_wb
//   misalign_trap                   only with MISALIGN_TRAP_EN: one-cycle trap flag with valid_wb
//
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses trap instead of
// issuing a bus request).
module mem_access #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_mem,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [XLEN-1:0] alu_mem,
  input  logic [XLEN-1:0] rs2_mem,
  input  logic [XLEN-1:0] instr_mem,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            valid_wb,
  output logic [XLEN-1:0] pc_wb,
  output logic [XLEN-1:0] instr_wb,
  output logic [XLEN-1:0] wb_data_wb,
`ifdef MISALIGN_TRAP_EN
  output logic            misalign_trap,
`endif
  output logic [XLEN-1:0] forward_mem
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {IDLE, BUSY} state_t;

  // ---------------------------------------------------------------- decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load;
  logic       is_store;
  logic       mem_op;
  logic [1:0] off;
  logic [1:0] size;

  assign opcode   = instr_mem[6:0];
  assign funct3   = instr_mem[14:12];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign mem_op   = valid_mem & (is_load | is_store);
  assign off      = alu_mem[1:0];

  // Undefined load/store widths fall back to word accesses.
  always_comb begin
    size = SZ_WORD;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b100: size = SZ_BYTE;
        3'b001, 3'b101: size = SZ_HALF;
        default:        size = SZ_WORD;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000:  size = SZ_BYTE;
        3'b001:  size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end
  end

  // ---------------------------------------------------------------- lanes
  logic [3:0]      be_calc;
  logic [XLEN-1:0] wdata_calc;
  logic [XLEN-1:0] addr_calc;
  logic            misaligned;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = rs2_mem;
    case (size)
      SZ_BYTE: begin
        be_calc    = 4'b0001 << off;
        wdata_calc = {4{rs2_mem[7:0]}};
      end
      SZ_HALF: begin
        be_calc    = off[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{rs2_mem[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = rs2_mem;
      end
    endcase
  end

  assign addr_calc  = {alu_mem[XLEN-1:2], 2'b00};
  assign misaligned = ((size == SZ_HALF) & off[0]) | ((size == SZ_WORD) & (off != 2'b00));

  // ---------------------------------------------------------------- load extract
  logic [XLEN-1:0] rdata_shift;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_result;

  assign rdata_shift = dmem_rdata >> {off, 3'b000};
  assign ld_byte     = rdata_shift[7:0];
  assign ld_half     = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (funct3)
      3'b000:  load_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_result = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_result = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_result = {{(XLEN-16){1'b0}}, ld_half};
      default: load_result = dmem_rdata;
    endcase
  end

  // A trapping access never reaches the bus; it retires as a plain WB write.
  logic trap_go;
  logic bus_go;
`ifdef MISALIGN_TRAP_EN
  assign trap_go = mem_op & misaligned;
`else
  assign trap_go = 1'b0;
  logic  unused_misaligned;
  assign unused_misaligned = misaligned;
`endif
  assign bus_go = mem_op & ~trap_go;

  // ---------------------------------------------------------------- FSM
  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            valid_wb_q, valid_wb_d;
  logic [XLEN-1:0] pc_wb_q, instr_wb_q, wb_data_q, wb_data_d;
  logic            trap_q, trap_d;
  logic            wb_load;
  logic            stall_c;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    valid_wb_d = 1'b0;
    wb_data_d  = alu_mem;
    trap_d     = 1'b0;
    wb_load    = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_go) begin
          stall_c = 1'b1;
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = addr_calc;
          be_d    = be_calc;
          wdata_d = wdata_calc;
        end else begin
          wb_load    = 1'b1;
          valid_wb_d = valid_mem;
          trap_d     = trap_go;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          // Inputs are still held by the stall, so decode/offset remain valid here.
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_load    = 1'b1;
          valid_wb_d = 1'b1;
          wb_data_d  = is_load ? load_result : alu_mem;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      valid_wb_q <= 1'b0;
      pc_wb_q    <= '0;
      instr_wb_q <= '0;
      wb_data_q  <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      valid_wb_q <= valid_wb_d;
      trap_q     <= trap_d;
      if (wb_load) begin
        pc_wb_q    <= pc_mem;
        instr_wb_q <= instr_mem;
        wb_data_q  <= wb_data_d;
      end
    end
  end

  assign stall       = stall_c;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign valid_wb    = valid_wb_q;
  assign pc_wb       = pc_wb_q;
  assign instr_wb    = instr_wb_q;
  assign wb_data_wb  = wb_data_q;
  assign forward_mem = wb_data_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
`else
  logic  unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Purpose : scoreboard bench for mem_access; directed loads/stores/ALU ops and reset mid-transfer.
// Latency : n/a (bench).
// Backpr. : n/a (bench drives dmem_ack with a fixed per-transaction wait).
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        valid_mem;
  logic [31:0] pc_mem, alu_mem, rs2_mem, instr_mem;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_wb;
  logic [31:0] pc_wb, instr_wb, wb_data_wb, forward_mem;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  mem_access #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_mem   (valid_mem),
    .pc_mem      (pc_mem),
    .alu_mem     (alu_mem),
    .rs2_mem     (rs2_mem),
    .instr_mem   (instr_mem),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .valid_wb    (valid_wb),
    .pc_wb       (pc_wb),
    .instr_wb    (instr_wb),
    .wb_data_wb  (wb_data_wb),
`ifdef MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap),
`endif
    .forward_mem (forward_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_LW  = 32'h0000_2083;
  localparam logic [31:0] I_LB  = 32'h0000_0083;
  localparam logic [31:0] I_LH  = 32'h0000_1083;
  localparam logic [31:0] I_LBU = 32'h0000_4083;
  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SH  = 32'h0000_1023;
  localparam logic [31:0] I_ADD = 32'h0000_0033;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wb;
    logic        trap;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] wb, input logic trap);
    exp_t e;
    e.pc = pc; e.instr = instr; e.wb = wb; e.trap = trap;
    exp_q.push_back(e);
  endtask

  // Monitor: every valid_wb must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_wb) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_wb: got wb_data 0x%08h expected no retirement at %0t",
                   wb_data_wb, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wb_data", wb_data_wb, e.wb);
          chk("forward_mem", forward_mem, e.wb);
          chk("pc_wb", pc_wb, e.pc);
          chk("instr_wb", instr_wb, e.instr);
`ifdef MISALIGN_TRAP_EN
          chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, e.trap});
`endif
        end
      end
    end
  end

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] alu, input logic [31:0] rs2);
    valid_mem = 1'b1;
    pc_mem    = pc;
    instr_mem = instr;
    alu_mem   = alu;
    rs2_mem   = rs2;
  endtask

  // waitc = BUSY cycles with req high before ack; stall is high for 1 + waitc cycles.
  task automatic mem_txn(input string nm, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] alu, input logic [31:0] rs2, input int waitc,
                         input logic [31:0] rdata, input logic exp_we, input logic [3:0] exp_be,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_wb);
    int stall_n;
    drive(pc, instr, alu, rs2);
    push_exp(pc, instr, exp_wb, 1'b0);
    @(negedge clk);
    stall_n = int'(stall);
    chk({nm, ".req_idle"}, {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < waitc; i++) begin
      @(negedge clk);
      stall_n += int'(stall);
      chk({nm, ".req_wait"}, {31'b0, dmem_req}, 32'd1);
      @(posedge clk); #1;
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    @(negedge clk);
    stall_n += int'(stall);
    chk({nm, ".stall_ack"}, {31'b0, stall}, 32'd0);
    chk({nm, ".req"}, {31'b0, dmem_req}, 32'd1);
    chk({nm, ".we"}, {31'b0, dmem_we}, {31'b0, exp_we});
    chk({nm, ".be"}, {28'b0, dmem_be}, {28'b0, exp_be});
    chk({nm, ".addr"}, dmem_addr, exp_addr);
    if (exp_we) chk({nm, ".wdata"}, dmem_wdata, exp_wdata);
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    valid_mem  = 1'b0;
    @(negedge clk);
    chk({nm, ".req_drop"}, {31'b0, dmem_req}, 32'd0);
    chk({nm, ".stall_cycles"}, stall_n, 1 + waitc);
    @(posedge clk); #1;
  endtask

  task automatic alu_txn(input string nm, input logic [31:0] pc, input logic [31:0] alu);
    drive(pc, I_ADD, alu, 32'h0);
    push_exp(pc, I_ADD, alu, 1'b0);
    @(negedge clk);
    chk({nm, ".stall"}, {31'b0, stall}, 32'd0);
    chk({nm, ".req"}, {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    valid_mem = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    valid_mem  = 1'b0;
    pc_mem     = 32'h0;
    alu_mem    = 32'h0;
    rs2_mem    = 32'h0;
    instr_mem  = 32'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;

    @(negedge clk);
    chk("rst.req", {31'b0, dmem_req}, 32'd0);
    chk("rst.valid_wb", {31'b0, valid_wb}, 32'd0);
    chk("rst.wb_data", wb_data_wb, 32'd0);
    chk("rst.be", {28'b0, dmem_be}, 32'd0);
    chk("rst.stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    alu_txn("add", 32'h1000, 32'h55);
    mem_txn("lw", 32'h1004, I_LW, 32'h100, 32'h0, 2, 32'hDEADBEEF,
            1'b0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF);
    mem_txn("lb", 32'h1008, I_LB, 32'h103, 32'h0, 1, 32'h80FF_0000,
            1'b0, 4'b1000, 32'h100, 32'h0, 32'hFFFF_FF80);
    mem_txn("lbu", 32'h100C, I_LBU, 32'h103, 32'h0, 0, 32'h80FF_0000,
            1'b0, 4'b1000, 32'h100, 32'h0, 32'h0000_0080);
    mem_txn("sh", 32'h1010, I_SH, 32'h102, 32'h1234ABCD, 1, 32'h0,
            1'b1, 4'b1100, 32'h100, 32'hABCDABCD, 32'h102);
    mem_txn("sb", 32'h1014, I_SB, 32'h201, 32'h000000AB, 0, 32'h0,
            1'b1, 4'b0010, 32'h200, 32'hABABABAB, 32'h201);
    mem_txn("lh", 32'h1018, I_LH, 32'h102, 32'h0, 0, 32'h8001_0000,
            1'b0, 4'b1100, 32'h100, 32'h0, 32'hFFFF_8001);

`ifdef MISALIGN_TRAP_EN
    drive(32'h101C, I_LW, 32'h101, 32'h0);
    push_exp(32'h101C, I_LW, 32'h101, 1'b1);
    @(negedge clk);
    chk("mis.stall", {31'b0, stall}, 32'd0);
    chk("mis.req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    valid_mem = 1'b0;
    @(negedge clk);
    chk("mis.req_after", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis.trap_drop", {31'b0, misalign_trap}, 32'd0);
    @(posedge clk); #1;
`else
    mem_txn("lw_mis", 32'h101C, I_LW, 32'h101, 32'h0, 0, 32'h11223344,
            1'b0, 4'b1111, 32'h100, 32'h0, 32'h11223344);
`endif

    // Reset while BUSY with ack arriving during reset: nothing may retire.
    drive(32'h1020, I_LW, 32'h300, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy.req", {31'b0, dmem_req}, 32'd1);
    #2;
    rst_n      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    valid_mem  = 1'b0;
    #1;
    chk("rstbusy.req_async", {31'b0, dmem_req}, 32'd0);
    chk("rstbusy.valid_wb", {31'b0, valid_wb}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy.req_hold", {31'b0, dmem_req}, 32'd0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstbusy.valid_after", {31'b0, valid_wb}, 32'd0);
    @(posedge clk); #1;

    alu_txn("add2", 32'h2000, 32'h77);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
